// File: rtl/btb_predictor_if.sv
// Fetch/execute/flush bundle of the branch target buffer.
// BTB_PERF_EN adds the perf_updates/perf_mispred counter outputs.
interface btb_predictor_if;
   logic [31:0] fetch_pc;
   logic        predicted_taken;
   logic [31:0] predicted_pc;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic [31:0] upd_target;
   logic        upd_taken;
   logic        upd_is_jump;
   logic        flush_req;
   logic        busy;
`ifdef BTB_PERF_EN
   logic [31:0] perf_updates;
   logic [31:0] perf_mispred;

   modport slave (
      input  fetch_pc, upd_valid, upd_pc, upd_target, upd_taken, upd_is_jump, flush_req,
      output predicted_taken, predicted_pc, busy, perf_updates, perf_mispred
   );
   modport master (
      output fetch_pc, upd_valid, upd_pc, upd_target, upd_taken, upd_is_jump, flush_req,
      input  predicted_taken, predicted_pc, busy, perf_updates, perf_mispred
   );
`else
   modport slave (
      input  fetch_pc, upd_valid, upd_pc, upd_target, upd_taken, upd_is_jump, flush_req,
      output predicted_taken, predicted_pc, busy
   );
   modport master (
      output fetch_pc, upd_valid, upd_pc, upd_target, upd_taken, upd_is_jump, flush_req,
      input  predicted_taken, predicted_pc, busy
   );
`endif
endinterface

// File: rtl/btb_predictor.sv
// Direct-mapped BTB with 2-bit direction counters and a one-entry-per-cycle flush sweep.
// Optional BTB_PERF_EN: saturating counters of accepted updates and mispredictions.
module btb_predictor #(
   parameter int ENTRIES = 16,
   parameter int IDX_W   = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   btb_predictor_if.slave  bus
);
   localparam int TAG_W = 30 - IDX_W;

   typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_e;

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [31:0]      target;
      logic [1:0]       ctr;
   } entry_t;

   localparam entry_t RESET_ENTRY = '{valid: 1'b0, tag: '0, target: '0, ctr: 2'b01};

   entry_t           entry_q [ENTRIES];
   state_e           state_q, state_d;
   logic [IDX_W-1:0] sweep_idx_q, sweep_idx_d;
   logic             sweep_active;

   // ---------------------------------------------------------------
   // Flush sequencer
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         sweep_idx_q <= '0;
      end else begin
         state_q     <= state_d;
         sweep_idx_q <= sweep_idx_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      sweep_idx_d = sweep_idx_q;
      case (state_q)
         IDLE: begin
            if (bus.flush_req) begin
               state_d     = SWEEP;
               sweep_idx_d = '0;
            end
         end
         SWEEP: begin
            // A repeated flush_req here is deliberately ignored.
            if (sweep_idx_q == IDX_W'(ENTRIES - 1)) begin
               state_d     = IDLE;
               sweep_idx_d = '0;
            end else begin
               sweep_idx_d = sweep_idx_q + 1'b1;
            end
         end
         default: begin
            state_d     = IDLE;
            sweep_idx_d = '0;
         end
      endcase
   end

   always_comb begin
      sweep_active = (state_q == SWEEP);
      bus.busy     = sweep_active;
   end

   // ---------------------------------------------------------------
   // Fetch-side lookup
   // ---------------------------------------------------------------
   logic [IDX_W-1:0] f_idx;
   logic [TAG_W-1:0] f_tag;
   entry_t           f_entry;
   logic             f_hit;
   logic             f_taken;

   always_comb begin
      f_idx   = bus.fetch_pc[IDX_W+1:2];
      f_tag   = bus.fetch_pc[31:IDX_W+2];
      f_entry = entry_q[f_idx];
      f_hit   = f_entry.valid && (f_entry.tag == f_tag) && !sweep_active;
      f_taken = f_hit && f_entry.ctr[1];
   end

   assign bus.predicted_taken = f_taken;
   assign bus.predicted_pc    = f_taken ? f_entry.target : bus.fetch_pc + 32'd4;

   // ---------------------------------------------------------------
   // Execute-side training
   // ---------------------------------------------------------------
   logic [IDX_W-1:0] u_idx;
   logic [TAG_W-1:0] u_tag;
   entry_t           u_entry;
   logic             u_hit;
   logic             upd_accept;
   logic             upd_we;
   entry_t           upd_entry_d;

   always_comb begin
      u_idx       = bus.upd_pc[IDX_W+1:2];
      u_tag       = bus.upd_pc[31:IDX_W+2];
      u_entry     = entry_q[u_idx];
      u_hit       = u_entry.valid && (u_entry.tag == u_tag);
      upd_accept  = bus.upd_valid && (state_q == IDLE);
      upd_we      = upd_accept && (u_hit || bus.upd_taken);
      upd_entry_d = u_entry;
      if (u_hit) begin
         if (bus.upd_is_jump) begin
            upd_entry_d.ctr    = 2'b11;
            upd_entry_d.target = bus.upd_target;
         end else if (bus.upd_taken) begin
            if (u_entry.ctr != 2'b11) upd_entry_d.ctr = u_entry.ctr + 2'b01;
            upd_entry_d.target = bus.upd_target;
         end else begin
            if (u_entry.ctr != 2'b00) upd_entry_d.ctr = u_entry.ctr - 2'b01;
         end
      end else begin
         // Allocation on a taken miss replaces whatever occupied the slot.
         upd_entry_d.valid  = 1'b1;
         upd_entry_d.tag    = u_tag;
         upd_entry_d.target = bus.upd_target;
         upd_entry_d.ctr    = bus.upd_is_jump ? 2'b11 : 2'b10;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
         logic clr_sel;
         logic upd_sel;

         assign clr_sel = sweep_active && (sweep_idx_q == IDX_W'(gi));
         assign upd_sel = upd_we && (u_idx == IDX_W'(gi));

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               entry_q[gi] <= RESET_ENTRY;
            end else if (clr_sel) begin
               entry_q[gi].valid <= 1'b0;
               entry_q[gi].ctr   <= 2'b01;
            end else if (upd_sel) begin
               entry_q[gi] <= upd_entry_d;
            end
         end
      end
   endgenerate

`ifdef BTB_PERF_EN
   // ---------------------------------------------------------------
   // Performance counters (survive flush, cleared only by reset)
   // ---------------------------------------------------------------
   logic [31:0] perf_updates_q, perf_updates_d;
   logic [31:0] perf_mispred_q, perf_mispred_d;
   logic        u_pred;

   always_comb begin
      u_pred         = u_hit && u_entry.ctr[1];
      perf_updates_d = perf_updates_q;
      perf_mispred_d = perf_mispred_q;
      if (upd_accept) begin
         if (perf_updates_q != 32'hFFFF_FFFF) perf_updates_d = perf_updates_q + 32'd1;
         if ((bus.upd_taken != u_pred) && (perf_mispred_q != 32'hFFFF_FFFF))
            perf_mispred_d = perf_mispred_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_updates_q <= '0;
         perf_mispred_q <= '0;
      end else begin
         perf_updates_q <= perf_updates_d;
         perf_mispred_q <= perf_mispred_d;
      end
   end

   assign bus.perf_updates = perf_updates_q;
   assign bus.perf_mispred = perf_mispred_q;
`endif

   // Word-aligned PCs: the byte-offset bits carry no information.
   logic unused_pc_lsbs;
   assign unused_pc_lsbs = ^{bus.fetch_pc[1:0], bus.upd_pc[1:0]};

endmodule

// File: tb/tb_btb_predictor.sv
// Directed self-checking bench for btb_predictor (16 entries).
module tb_btb_predictor;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   btb_predictor_if bus ();

   btb_predictor #(.ENTRIES(16), .IDX_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
      $display("check %-14s observed=0x%08h expected=0x%08h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic taken, input logic jump);
      bus.upd_pc      = pc;
      bus.upd_target  = tgt;
      bus.upd_taken   = taken;
      bus.upd_is_jump = jump;
      bus.upd_valid   = 1'b1;
      tick();
      bus.upd_valid   = 1'b0;
      $display("upd pc=0x%08h target=0x%08h taken=%0b jump=%0b", pc, tgt, taken, jump);
   endtask

   task automatic look(input string tag, input logic [31:0] pc, input logic exp_taken, input logic [31:0] exp_pc);
      bus.fetch_pc = pc;
      #1;
      check({tag, ".tk"}, {31'd0, bus.predicted_taken}, {31'd0, exp_taken});
      check({tag, ".pc"}, bus.predicted_pc, exp_pc);
      tick();
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (bus.busy && n < 64) begin
         n++;
         tick();
      end
      check({tag, ".idle"}, {31'd0, bus.busy}, 32'd0);
   endtask

   initial begin
      int cnt;
      checks = 0;
      errors = 0;
      rst_n           = 1'b0;
      bus.fetch_pc    = 32'h100;
      bus.upd_valid   = 1'b0;
      bus.upd_pc      = '0;
      bus.upd_target  = '0;
      bus.upd_taken   = 1'b0;
      bus.upd_is_jump = 1'b0;
      bus.flush_req   = 1'b0;

      // Reset state
      #2;
      check("rst.tk", {31'd0, bus.predicted_taken}, 32'd0);
      check("rst.pc", bus.predicted_pc, 32'h104);
      check("rst.busy", {31'd0, bus.busy}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // Allocate then weaken
      upd(32'h100, 32'h200, 1'b1, 1'b0);
      look("alloc", 32'h100, 1'b1, 32'h200);
      bus.fetch_pc    = 32'h100;
      bus.upd_pc      = 32'h100;
      bus.upd_target  = 32'h999;
      bus.upd_taken   = 1'b0;
      bus.upd_is_jump = 1'b0;
      bus.upd_valid   = 1'b1;
      #1;
      check("nobypass", bus.predicted_pc, 32'h200);
      tick();
      bus.upd_valid = 1'b0;
      look("weak", 32'h100, 1'b0, 32'h104);

      // Aliasing at index 0
      upd(32'h100, 32'h200, 1'b1, 1'b0);
      upd(32'h140, 32'h300, 1'b1, 1'b0);
      look("alias.old", 32'h100, 1'b0, 32'h104);
      look("alias.new", 32'h140, 1'b1, 32'h300);

      // Saturation
      for (int i = 0; i < 4; i++) upd(32'h80, 32'h400, 1'b1, 1'b0);
      upd(32'h80, 32'h400, 1'b0, 1'b0);
      look("sat.hi", 32'h80, 1'b1, 32'h400);
      for (int i = 0; i < 5; i++) upd(32'h80, 32'h400, 1'b0, 1'b0);
      look("sat.lo", 32'h80, 1'b0, 32'h84);
      upd(32'h80, 32'h400, 1'b1, 1'b0);
      look("sat.01", 32'h80, 1'b0, 32'h84);
      upd(32'h80, 32'h480, 1'b1, 1'b0);
      look("sat.10", 32'h80, 1'b1, 32'h480);

      // Jumps and not-taken misses
      upd(32'h10, 32'h1000, 1'b1, 1'b1);
      upd(32'h10, 32'h1000, 1'b0, 1'b0);
      look("jump", 32'h10, 1'b1, 32'h1000);
      upd(32'h20, 32'h2000, 1'b0, 1'b0);
      look("miss.nt", 32'h20, 1'b0, 32'h24);
      look("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

      // Fill, flush, count busy cycles
      for (int i = 0; i < 16; i++) upd(32'h1000 + 32'(i * 4), 32'h2000 + 32'(i * 4), 1'b1, 1'b0);
      look("fill", 32'h1004, 1'b1, 32'h2004);
      bus.flush_req = 1'b1;
      tick();
      bus.flush_req = 1'b0;
      check("flush.busy", {31'd0, bus.busy}, 32'd1);
      cnt = 0;
      while (bus.busy && cnt < 40) begin
         if (cnt == 0) begin
            bus.fetch_pc = 32'h103C;
            #1;
            check("busy.miss", {31'd0, bus.predicted_taken}, 32'd0);
         end
         if (cnt == 2) begin
            bus.upd_pc      = 32'h3000;
            bus.upd_target  = 32'h3300;
            bus.upd_taken   = 1'b1;
            bus.upd_is_jump = 1'b0;
            bus.upd_valid   = 1'b1;
         end
         if (cnt == 3) bus.upd_valid = 1'b0;
         if (cnt == 5) bus.flush_req = 1'b1;
         if (cnt == 6) bus.flush_req = 1'b0;
         cnt++;
         tick();
      end
      check("busy.cycles", 32'(cnt), 32'd16);
      for (int i = 0; i < 16; i++) look("flushed", 32'h1000 + 32'(i * 4), 1'b0, 32'h1004 + 32'(i * 4));
      look("dropped", 32'h3000, 1'b0, 32'h3004);

      // Update in the same cycle as flush_req is applied, then swept
      bus.upd_pc      = 32'h500;
      bus.upd_target  = 32'h5500;
      bus.upd_taken   = 1'b1;
      bus.upd_is_jump = 1'b0;
      bus.upd_valid   = 1'b1;
      bus.flush_req   = 1'b1;
      tick();
      bus.upd_valid = 1'b0;
      bus.flush_req = 1'b0;
      wait_idle("same");
      look("same.swept", 32'h500, 1'b0, 32'h504);

      // Reset in the middle of a sweep
      upd(32'h63C, 32'h700, 1'b1, 1'b0);
      look("pre.rst", 32'h63C, 1'b1, 32'h700);
      bus.flush_req = 1'b1;
      tick();
      bus.flush_req = 1'b0;
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst.busy", {31'd0, bus.busy}, 32'd0);
      bus.fetch_pc = 32'h63C;
      #1;
      check("midrst.pc", bus.predicted_pc, 32'h640);
      rst_n = 1'b1;
      tick();
      check("midrst.idle", {31'd0, bus.busy}, 32'd0);
      look("midrst.miss", 32'h63C, 1'b0, 32'h640);

`ifdef BTB_PERF_EN
      // Counters: 3 accepted updates, only the second mispredicted
      upd(32'h700, 32'h7700, 1'b0, 1'b0);
      upd(32'h700, 32'h7700, 1'b1, 1'b0);
      upd(32'h700, 32'h7700, 1'b1, 1'b0);
      check("perf.upd", bus.perf_updates, 32'd3);
      check("perf.mis", bus.perf_mispred, 32'd1);
      bus.flush_req = 1'b1;
      tick();
      bus.flush_req = 1'b0;
      wait_idle("perf");
      check("perf.upd.fl", bus.perf_updates, 32'd3);
      check("perf.mis.fl", bus.perf_mispred, 32'd1);
      rst_n = 1'b0;
      #1;
      check("perf.upd.rst", bus.perf_updates, 32'd0);
      check("perf.mis.rst", bus.perf_mispred, 32'd0);
      rst_n = 1'b1;
      tick();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/btb_predictor.md
Name: btb_predictor

Overview:
- Direct-mapped branch target buffer with 2-bit saturating direction counters.
- Fetch-side lookup produces `predicted_taken` and `predicted_pc`. Execute-stage branch/jump resolution trains the entries through the update port.
- Includes a multi-cycle flush sequencer that invalidates all entries, e.g. on `fence.i` or context change.

Parameters:
- ENTRIES, 16, number of BTB entries; power of two, at least 2.
- IDX_W, 4, index width; must equal log2(ENTRIES). Tag width is 30-IDX_W (pc[31:2+IDX_W]).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_pc  in  32  PC being fetched.
- predicted_taken  out  1  lookup hit with counter bit[1] set.
- predicted_pc  out  32  next-PC prediction.
- upd_valid  in  1  resolved branch/jump present in execute (update_btb).
- upd_pc  in  32  PC of the resolved instruction.
- upd_target  in  32  resolved jump address.
- upd_taken  in  1  actual outcome (modify_pc XOR execute-stage predicted flag).
- upd_is_jump  in  1  JAL/JALR; unconditional.
- flush_req  in  1  single-cycle pulse requesting full invalidation.
- busy  out  1  flush sweep in progress.

Behaviour:
- Per-entry state: valid, tag[30-IDX_W], target[32], ctr[2] (00 SNT, 01 WNT, 10 WT, 11 ST).
- Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]; pc[1:0] ignored.
- Reset, asynchronous: all valid=0, ctr=01, target=0, tag=0, FSM=IDLE, busy=0.
- Lookup, combinational from registered state:
  - hit = valid[idx] && tag match && !busy.
  - predicted_taken = hit && ctr[1].
  - predicted_pc = predicted_taken ? target[idx] : fetch_pc+4, modulo 2^32 (0xFFFFFFFC+4 wraps to 0).
- Update, applied at the clock edge, only when upd_valid && FSM==IDLE:
  - Tag hit, taken: ctr saturating +1 (11 stays 11); target overwritten with upd_target.
  - Tag hit, not taken: ctr saturating -1 (00 stays 00); target unchanged.
  - Hit with upd_is_jump: ctr forced to 11; target overwritten.
  - Miss (invalid or tag mismatch) and taken: allocate and replace. valid=1, tag written, target=upd_target, ctr=11 if upd_is_jump else 10.
  - Miss and not taken: no change.
- Same-cycle lookup and update at the same index: lookup returns pre-update state (no bypass). New state is visible the following cycle.
- Flush FSM, states IDLE and SWEEP:
  - IDLE, flush_req=1: go to SWEEP, sweep index=0, busy=1 from the next cycle.
  - SWEEP: each cycle clear valid[sweep index] and set ctr to 01. When index==ENTRIES-1, return to IDLE. busy=1 for exactly ENTRIES cycles.
  - flush_req while in SWEEP is ignored; the sweep does not restart.
  - Updates arriving while busy are dropped.
  - flush_req and upd_valid in the same IDLE cycle: the update is applied, then the sweep clears it.
- rst_n asserted mid-sweep: immediate return to IDLE, all entries invalid.

Optional Feature:
- Macro BTB_PERF_EN.
- Defined: adds outputs perf_updates[32] and perf_mispred[32].
  - perf_updates counts accepted updates.
  - perf_mispred counts accepted updates where upd_taken differs from the state-based prediction at upd_pc (hit && ctr[1]).
  - Both saturate at 0xFFFFFFFF, are reset to 0 by rst_n, and are not cleared by flush.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then fetch_pc=0x100 -> predicted_taken=0, predicted_pc=0x104, busy=0.
- Update pc=0x100, target=0x200, taken=1, is_jump=0; next cycle fetch 0x100 -> taken=1, pc=0x200 (ctr=10). One not-taken update -> ctr=01, predicted_pc=0x104.
- Alias: allocate 0x100 (taken), then taken update at 0x140 (same idx, ENTRIES=16) -> fetch 0x100 misses (pc=0x104); fetch 0x140 hits, target per update.
- Saturation: four taken updates at 0x80, then one not-taken -> still predicted taken (11 goes to 10). Five not-taken -> ctr=00, no underflow.
- Flush: fill all 16 entries, pulse flush_req -> busy high exactly 16 cycles. An update during busy is dropped. All lookups miss afterward. A second flush_req mid-sweep does not extend busy.
- With BTB_PERF_EN: 3 updates, 1 mispredicted -> perf_updates=3, perf_mispred=1. Flush -> counters unchanged. rst_n low -> both 0.
